// File: rtl/multi_pulse_stretcher_pkg.sv
// Shared definitions for the multi-channel pulse stretcher: default sizing,
// trigger-mode encodings and the per-cycle trigger classification.
package multi_pulse_stretcher_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    // Trigger-mode encodings for the EDGE_DET parameter.
    localparam int EDGE_DET_LEVEL = 0;
    localparam int EDGE_DET_RISE  = 1;

    // Longest window the default counter width can express.
    localparam int MAX_LEN = (1 << DEF_CNT_W) - 1;

    // What a channel does with the trigger seen in the current cycle.
    typedef enum logic [1:0] {
        TRIG_NONE   = 2'd0,
        TRIG_ACCEPT = 2'd1,
        TRIG_DROP   = 2'd2
    } trig_act_e;

endpackage

// File: rtl/multi_pulse_stretcher_chan.sv
// One stretcher channel: trigger detection, window down-counter and the
// registered pulse_out / trig_drop flags.
module multi_pulse_stretcher_chan
    import multi_pulse_stretcher_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EDGE_DET = EDGE_DET_RISE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             retrig_en,
    input  logic [CNT_W-1:0] stretch_len,
    input  logic             pulse_in,
    output logic             pulse_out,
    output logic             trig_drop
);

    logic             prev_q, prev_d;
    logic             out_q, out_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] len_m1;
    logic             trig;
    logic             mid_window;
    trig_act_e        act;

    // Trigger detection and classification; a zero length behaves as one cycle,
    // so the reload value is simply stretch_len-1 clamped at zero.
    always_comb begin
        len_m1     = (stretch_len == '0) ? '0 : stretch_len - CNT_W'(1);
        trig       = (EDGE_DET == EDGE_DET_RISE) ? (pulse_in & ~prev_q) : pulse_in;
        // On the last high cycle (cnt==0) a trigger is a fresh start, not a retrigger.
        mid_window = out_q && (cnt_q != '0);
        act        = TRIG_NONE;
        if (enable && trig) begin
            act = (mid_window && !retrig_en) ? TRIG_DROP : TRIG_ACCEPT;
        end
    end

    // Next-state for the window counter, output and drop flag.
    always_comb begin
        prev_d = pulse_in;
        out_d  = out_q;
        cnt_d  = cnt_q;
        drop_d = 1'b0;
        case (act)
            TRIG_ACCEPT: begin
                out_d = 1'b1;
                cnt_d = len_m1;
            end
            TRIG_DROP: begin
                drop_d = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
            end
            default: begin
                if (out_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        out_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            out_q  <= 1'b0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pulse_out = out_q;
    assign trig_drop = drop_q;

endmodule

// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher: NUM_CH independent channels sharing the
// length and mode controls, plus a combinational busy summary.
module multi_pulse_stretcher
    import multi_pulse_stretcher_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EDGE_DET = EDGE_DET_RISE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              retrig_en,
    input  logic [CNT_W-1:0]  stretch_len,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] trig_drop,
    output logic              busy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        multi_pulse_stretcher_chan #(
            .CNT_W    (CNT_W),
            .EDGE_DET (EDGE_DET)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .retrig_en   (retrig_en),
            .stretch_len (stretch_len),
            .pulse_in    (pulse_in[g]),
            .pulse_out   (pulse_out[g]),
            .trig_drop   (trig_drop[g])
        );
    end

    // busy follows the registered outputs directly, so it clears with reset.
    always_comb begin
        busy = |pulse_out;
    end

endmodule
